// File: rtl/universal_ff_bank.sv
// universal_ff_bank: WIDTH-bit bank of run-time selectable D/T/SR/JK flip-flops
// with per-bit enable, SR=11 policy, sticky illegal flags, a saturating
// illegal-event counter and per-bit change pulses.
module universal_ff_bank #(
  parameter int unsigned           WIDTH     = 8,
  parameter logic [WIDTH-1:0]      RST_VAL   = {WIDTH{1'b0}},
  parameter int unsigned           SR_POLICY = 0,
  parameter int unsigned           CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] en_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             err_clr_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] qbar_o,
  output logic [WIDTH-1:0] chg_o,
  output logic [WIDTH-1:0] err_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    MODE_D  = 2'b00,
    MODE_T  = 2'b01,
    MODE_SR = 2'b10,
    MODE_JK = 2'b11
  } mode_e;

  mode_e            mode;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] chg_q, chg_d;
  logic [WIDTH-1:0] err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_both;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] illegal;
  logic [CNT_W-1:0] cnt_base;

  assign mode = mode_e'(mode_i);

  // Result applied to bits that see S=R=1 in SR mode
  always_comb begin
    sr_both = q_q;
    case (SR_POLICY)
      1:       sr_both = {WIDTH{1'b1}};
      2:       sr_both = {WIDTH{1'b0}};
      3:       sr_both = ~q_q;
      default: sr_both = q_q;
    endcase
  end

  // Next-state, illegal detection, sticky flags and saturating counter
  always_comb begin
    nxt      = q_q;
    illegal  = {WIDTH{1'b0}};
    cnt_base = cnt_q;
    cnt_d    = cnt_q;
    case (mode)
      MODE_D:  nxt = a_i;
      MODE_T:  nxt = q_q ^ a_i;
      MODE_SR: begin
        nxt     = (a_i & ~b_i) | (q_q & ~a_i & ~b_i) | (a_i & b_i & sr_both);
        illegal = en_i & a_i & b_i;
      end
      MODE_JK: nxt = (a_i & ~b_i) | (q_q & ~a_i & ~b_i) | (a_i & b_i & ~q_q);
      default: nxt = q_q;
    endcase
    q_d   = (en_i & nxt) | (~en_i & q_q);
    chg_d = q_d ^ q_q;
    // A new illegal event on a clearing edge survives the clear
    err_d = err_clr_i ? illegal : (err_q | illegal);
    if (err_clr_i) begin
      cnt_base = {CNT_W{1'b0}};
    end
    cnt_d = cnt_base;
    if ((|illegal) && (cnt_base != CNT_MAX)) begin
      cnt_d = cnt_base + CNT_W'(1);
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q   <= RST_VAL;
      chg_q <= {WIDTH{1'b0}};
      err_q <= {WIDTH{1'b0}};
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      q_q   <= q_d;
      chg_q <= chg_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign q_o       = q_q;
  assign qbar_o    = ~q_q;
  assign chg_o     = chg_q;
  assign err_o     = err_q;
  assign err_cnt_o = cnt_q;

endmodule

// File: tb/tb_universal_ff_bank.sv
// tb_universal_ff_bank: four banks (SR_POLICY 0..3) driven in parallel and
// checked against a per-bit behavioural model.
module tb_universal_ff_bank;

  localparam logic [7:0] RV = 8'hA5;

  logic       clk;
  logic       rst;
  logic [1:0] mode;
  logic [7:0] en, a, b;
  logic       err_clr;

  logic [7:0] q_w[4], qb_w[4], chg_w[4], err_w[4], cnt_w[4];
  logic [7:0] cnt0;
  logic [1:0] cnt_s[4];

  int checks   = 0;
  int failures = 0;

  // Model state
  logic [7:0] m_q[4], m_chg[4], m_err[4];
  int         m_cnt[4];
  int         m_max[4] = '{255, 3, 3, 3};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  universal_ff_bank #(.WIDTH(8), .RST_VAL(RV), .SR_POLICY(0), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst(rst), .mode_i(mode), .en_i(en), .a_i(a), .b_i(b),
    .err_clr_i(err_clr), .q_o(q_w[0]), .qbar_o(qb_w[0]), .chg_o(chg_w[0]),
    .err_o(err_w[0]), .err_cnt_o(cnt0)
  );

  for (genvar g = 1; g < 4; g++) begin : g_pol
    universal_ff_bank #(.WIDTH(8), .RST_VAL(RV), .SR_POLICY(g), .CNT_W(2)) u_dut (
      .clk(clk), .rst(rst), .mode_i(mode), .en_i(en), .a_i(a), .b_i(b),
      .err_clr_i(err_clr), .q_o(q_w[g]), .qbar_o(qb_w[g]), .chg_o(chg_w[g]),
      .err_o(err_w[g]), .err_cnt_o(cnt_s[g])
    );
  end

  assign cnt_s[0]  = 2'b00;
  assign cnt_w[0]  = cnt0;
  assign cnt_w[1]  = {6'b0, cnt_s[1]};
  assign cnt_w[2]  = {6'b0, cnt_s[2]};
  assign cnt_w[3]  = {6'b0, cnt_s[3]};

  task automatic model_reset();
    for (int d = 0; d < 4; d++) begin
      m_q[d] = RV; m_chg[d] = 8'h00; m_err[d] = 8'h00; m_cnt[d] = 0;
    end
  endtask

  // One rising edge of the reference: policy index equals the bank index
  task automatic model_edge();
    logic [7:0] nq, ill;
    for (int d = 0; d < 4; d++) begin
      nq  = m_q[d];
      ill = 8'h00;
      for (int i = 0; i < 8; i++) begin
        if (en[i]) begin
          case (mode)
            2'd0: nq[i] = a[i];
            2'd1: nq[i] = m_q[d][i] ^ a[i];
            2'd2: begin
              if (a[i] && b[i]) begin
                ill[i] = 1'b1;
                if (d == 1)      nq[i] = 1'b1;
                else if (d == 2) nq[i] = 1'b0;
                else if (d == 3) nq[i] = ~m_q[d][i];
              end else if (a[i]) nq[i] = 1'b1;
              else if (b[i])     nq[i] = 1'b0;
            end
            default: begin
              if (a[i] && b[i]) nq[i] = ~m_q[d][i];
              else if (a[i])    nq[i] = 1'b1;
              else if (b[i])    nq[i] = 1'b0;
            end
          endcase
        end
      end
      m_chg[d] = nq ^ m_q[d];
      m_q[d]   = nq;
      if (err_clr) begin
        m_err[d] = ill;
        m_cnt[d] = (ill != 0) ? 1 : 0;
      end else begin
        m_err[d] = m_err[d] | ill;
        if (ill != 0 && m_cnt[d] < m_max[d]) m_cnt[d]++;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic [1:0] m, input logic [7:0] e, input logic [7:0] av,
                       input logic [7:0] bv, input logic c);
    mode = m; en = e; a = av; b = bv; err_clr = c;
  endtask

  task automatic test_reset();
    drive(2'd0, 8'h00, 8'h00, 8'h00, 1'b0);
    rst = 1'b1;
    model_reset();
    #12;
    for (int d = 0; d < 4; d++) begin
      checks++; if (q_w[d] !== 8'hA5) begin failures++; $display("FAIL reset_q dut%0d got %h exp a5", d, q_w[d]); end
      checks++; if (qb_w[d] !== 8'h5A) begin failures++; $display("FAIL reset_qbar dut%0d got %h exp 5a", d, qb_w[d]); end
      checks++; if (chg_w[d] !== 8'h00 || err_w[d] !== 8'h00 || cnt_w[d] !== 8'h00) begin
        failures++; $display("FAIL reset_flags dut%0d chg=%h err=%h cnt=%0d exp 0", d, chg_w[d], err_w[d], cnt_w[d]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_d_mode();
    drive(2'd0, 8'hFF, 8'h3C, 8'h00, 1'b0);
    step();
    checks++; if (q_w[0] !== 8'h3C) begin failures++; $display("FAIL d_load got %h exp 3c", q_w[0]); end
    checks++; if (chg_w[0] !== 8'h99) begin failures++; $display("FAIL d_chg got %h exp 99", chg_w[0]); end
    step();
    checks++; if (chg_w[0] !== 8'h00) begin failures++; $display("FAIL d_chg_clear got %h exp 00", chg_w[0]); end
  endtask

  task automatic test_t_jk();
    logic [7:0] exp_t[3] = '{8'h0F, 8'h00, 8'h0F};
    drive(2'd0, 8'hFF, 8'h00, 8'h00, 1'b0);
    step();
    drive(2'd1, 8'hFF, 8'h0F, 8'h00, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (q_w[0] !== exp_t[k]) begin failures++; $display("FAIL t_seq%0d got %h exp %h", k, q_w[0], exp_t[k]); end
    end
    drive(2'd0, 8'hFF, 8'hF0, 8'h00, 1'b0);
    step();
    drive(2'd3, 8'hFF, 8'hFF, 8'hFF, 1'b0);
    step();
    checks++; if (q_w[0] !== 8'h0F) begin failures++; $display("FAIL jk_toggle got %h exp 0f", q_w[0]); end
    drive(2'd3, 8'hFF, 8'h01, 8'h02, 1'b0);
    step();
    checks++; if (q_w[0] !== 8'h0D) begin failures++; $display("FAIL jk_set_reset got %h exp 0d", q_w[0]); end
  endtask

  task automatic test_sr_policy();
    logic [7:0] exp_q[4] = '{8'h55, 8'hFF, 8'h00, 8'hAA};
    drive(2'd0, 8'hFF, 8'h55, 8'h00, 1'b0);
    step();
    drive(2'd2, 8'hFF, 8'hFF, 8'hFF, 1'b0);
    step();
    for (int d = 0; d < 4; d++) begin
      checks++; if (q_w[d] !== exp_q[d]) begin failures++; $display("FAIL sr_policy%0d_q got %h exp %h", d, q_w[d], exp_q[d]); end
      checks++; if (err_w[d] !== 8'hFF) begin failures++; $display("FAIL sr_policy%0d_err got %h exp ff", d, err_w[d]); end
      checks++; if (cnt_w[d] !== 8'd1) begin failures++; $display("FAIL sr_policy%0d_cnt got %0d exp 1", d, cnt_w[d]); end
      checks++; if (chg_w[d] !== (exp_q[d] ^ 8'h55)) begin failures++; $display("FAIL sr_policy%0d_chg got %h exp %h", d, chg_w[d], exp_q[d] ^ 8'h55); end
    end
    // Clear flags with a legal input
    drive(2'd0, 8'h00, 8'h00, 8'h00, 1'b1);
    step();
    checks++; if (err_w[0] !== 8'h00 || cnt_w[0] !== 8'd0) begin
      failures++; $display("FAIL sr_clear err=%h cnt=%0d exp 0", err_w[0], cnt_w[0]);
    end
  endtask

  task automatic test_enable_and_saturation();
    logic [7:0] q_before = q_w[0];
    int         exp_sat[5] = '{1, 2, 3, 3, 3};
    drive(2'd2, 8'h01, 8'hFF, 8'hFF, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step();
      if (k == 0) begin
        checks++; if (err_w[0] !== 8'h01) begin failures++; $display("FAIL en_mask_err got %h exp 01", err_w[0]); end
        checks++; if (cnt_w[0] !== 8'd1) begin failures++; $display("FAIL en_mask_cnt got %0d exp 1", cnt_w[0]); end
        checks++; if (q_w[0][7:1] !== q_before[7:1]) begin failures++; $display("FAIL en_mask_q got %h exp %h in [7:1]", q_w[0], q_before); end
      end
      checks++; if (cnt_w[1] !== 8'(exp_sat[k])) begin failures++; $display("FAIL sat%0d got %0d exp %0d", k, cnt_w[1], exp_sat[k]); end
    end
    checks++; if (cnt_w[0] !== 8'd5) begin failures++; $display("FAIL cnt8_no_sat got %0d exp 5", cnt_w[0]); end
    drive(2'd2, 8'h01, 8'hFF, 8'hFF, 1'b1);
    step();
    for (int d = 0; d < 4; d++) begin
      checks++; if (cnt_w[d] !== 8'd1 || err_w[d] !== 8'h01) begin
        failures++; $display("FAIL clr_vs_illegal dut%0d cnt=%0d err=%h exp 1/01", d, cnt_w[d], err_w[d]);
      end
    end
    drive(2'd2, 8'hFF, 8'h00, 8'h00, 1'b1);
    step();
    for (int d = 0; d < 4; d++) begin
      checks++; if (cnt_w[d] !== 8'd0 || err_w[d] !== 8'h00) begin
        failures++; $display("FAIL clr_legal dut%0d cnt=%0d err=%h exp 0/00", d, cnt_w[d], err_w[d]);
      end
    end
  endtask

  task automatic test_async_reset();
    drive(2'd2, 8'hFF, 8'hFF, 8'hFF, 1'b0);
    step();
    drive(2'd1, 8'hFF, 8'hFF, 8'h00, 1'b0);
    step();
    step();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    for (int d = 0; d < 4; d++) begin
      checks++; if (q_w[d] !== RV || err_w[d] !== 8'h00 || cnt_w[d] !== 8'd0 || chg_w[d] !== 8'h00) begin
        failures++; $display("FAIL async_rst dut%0d q=%h err=%h cnt=%0d chg=%h", d, q_w[d], err_w[d], cnt_w[d], chg_w[d]);
      end
    end
    rst = 1'b0;
    step();
    for (int d = 0; d < 4; d++) begin
      checks++; if (q_w[d] !== 8'h5A || chg_w[d] !== 8'hFF) begin
        failures++; $display("FAIL post_rst_t dut%0d q=%h chg=%h exp 5a/ff", d, q_w[d], chg_w[d]);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 8'($urandom),
            ($urandom_range(0, 7) == 0));
      step();
      for (int d = 0; d < 4; d++) begin
        checks++; if (q_w[d] !== m_q[d] || qb_w[d] !== ~m_q[d]) begin
          failures++; $display("FAIL rand_q n%0d dut%0d got %h/%h exp %h", n, d, q_w[d], qb_w[d], m_q[d]);
        end
        checks++; if (chg_w[d] !== m_chg[d]) begin
          failures++; $display("FAIL rand_chg n%0d dut%0d got %h exp %h", n, d, chg_w[d], m_chg[d]);
        end
        checks++; if (err_w[d] !== m_err[d] || cnt_w[d] !== 8'(m_cnt[d])) begin
          failures++; $display("FAIL rand_err n%0d dut%0d got %h/%0d exp %h/%0d", n, d, err_w[d], cnt_w[d], m_err[d], m_cnt[d]);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    test_reset();
    test_d_mode();
    test_t_jk();
    test_sr_policy();
    test_enable_and_saturation();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/universal_ff_bank.md
Name: universal_ff_bank

Overview:
- Parametrised bank of WIDTH flip-flop cells sharing one clock.
- A run-time mode input selects D, T, SR or JK next-state behaviour for all bits.
- Adds per-bit enable, a defined policy for the illegal SR=11 input, sticky per-bit illegal flags, a saturating illegal-event counter and per-bit change pulses.
- Serves as the general-purpose state-element primitive for control logic in the design.

Parameters:
- WIDTH, 8, number of flip-flop bits.
- RST_VAL, {WIDTH{1'b0}}, value loaded into q on reset.
- SR_POLICY, 0, action on SR=11: 0 hold, 1 force 1, 2 force 0, 3 toggle.
- CNT_W, 8, width of the illegal-event counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- mode  in  2  00 D, 01 T, 10 SR, 11 JK.
- en  in  WIDTH  per-bit clock enable; bit holds when 0.
- a  in  WIDTH  D / T / S / J input per bit.
- b  in  WIDTH  R / K input per bit; ignored in D and T modes.
- err_clr  in  1  synchronous clear of err and err_cnt.
- q  out  WIDTH  flip-flop state.
- qbar  out  WIDTH  combinational ~q.
- chg  out  WIDTH  registered pulse: bit i of q changed on this edge.
- err  out  WIDTH  sticky flag: bit i saw S=R=1 while enabled in SR mode.
- err_cnt  out  CNT_W  saturating count of edges with at least one illegal bit.

Behaviour:
- Reset (rst=1, asynchronous, any time): q=RST_VAL, chg=0, err=0, err_cnt=0 immediately, independent of clk. Deassertion takes effect from the next rising edge. A reset asserted mid-sequence discards all in-flight state.
- Per bit i on a rising edge with en[i]=1, next q[i] by mode:
  - D: a[i].
  - T: q[i]^a[i].
  - SR:
    - a=0, b=0: hold.
    - a=0, b=1: 0.
    - a=1, b=0: 1.
    - a=1, b=1: SR_POLICY result. q never goes X.
  - JK:
    - 00 hold; 01 reset to 0; 10 set to 1; 11 toggle.
- en[i]=0: q[i] holds in all modes. The bit cannot flag illegal and cannot assert chg.
- A mode change takes effect on the same edge it is sampled. There is no pipeline; latency from inputs to q is 1 cycle.
- chg[i] is registered as (next q[i] != q[i]). It is high for exactly the cycle after the edge that changed q[i]. Holds and same-value loads give 0.
- Illegal event for bit i: mode=10, en[i]=1, a[i]=1, b[i]=1.
  - err[i] sets on the edge that samples it and stays set until err_clr or rst.
  - err_cnt increments by 1 per edge with any illegal bit, not per bit. It saturates at 2^CNT_W-1 with no wrap.
- err_clr=1 on an edge: err and err_cnt go to 0. If an illegal event is sampled on the same edge, set/increment wins: err gets the new bits only, err_cnt becomes 1. err_clr does not affect q or chg.
- qbar is always ~q, including during reset.
- SR_POLICY values outside 0-3 are not legal; behaviour is undefined and the bench does not test them.

Test Plan:
- Reset and D mode:
  - WIDTH=8, RST_VAL=8'hA5. Pulse rst between edges → q=A5 immediately, qbar=5A.
  - mode=00, en=FF, a=3C → q=3C after 1 edge.
  - chg=99 for one cycle, then chg=00.
- T and JK modes:
  - q=00, mode=01, a=0F, en=FF, 3 edges → q sequence 0F, 00, 0F.
  - mode=11, q=F0, a=FF, b=FF → q=0F.
  - a=01, b=02 → q bit0 set to 1, bit1 reset to 0.
- SR policy:
  - SR_POLICY=0, q=55, mode=10, a=FF, b=FF → q stays 55, chg=00, err=FF, err_cnt=1.
  - Repeat with SR_POLICY=1, 2 and 3 → q=FF, 00 and AA respectively.
- Enable masking:
  - mode=10, en=01, a=FF, b=FF → only err[0] set, err_cnt=1, q[7:1] unchanged.
- Counter saturation and clear:
  - CNT_W=2, illegal input held for 5 edges → err_cnt 1, 2, 3, 3, 3.
  - err_clr with illegal input still present → err_cnt=1.
  - err_clr with legal input → err=00, err_cnt=0.
- Async reset mid-operation:
  - Toggling in T mode, assert rst mid-cycle → q=RST_VAL, err=0, err_cnt=0 before the next edge.
  - First edge after release applies normal T behaviour.
